mc_8x8_ctrl: RTL and testbench

Sequencing controller that drives the 8x8 complementary-memristor array (`MC_8x8_FULL_upd`) from a simple request/response port. It converts one-row write or read requests into the word-line, bit-line, select-line and data-line sequences the array needs. For reads it captures the array output. It is the initiator for the array's command interface and sits between the bayesian compute core and the array instance.

---
 rtl/mc_8x8_ctrl.sv | 113 +++++++++++
 tb/tb_mc_8x8_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mc_8x8_ctrl.sv
// mc_8x8_ctrl: sequences one-row write/read requests onto the 8x8 complementary-memristor array lines.
module mc_8x8_ctrl #(
    parameter int PULSE_CYC = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_we_i,
    input  logic [2:0] req_row_i,
    input  logic [7:0] req_wdata_i,
    input  logic [7:0] req_wmask_i,
    input  logic [7:0] req_din_i,
    input  logic [7:0] req_dinb_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [3:0] cwle_o,
    output logic [3:0] cwlo_o,
    output logic [7:0] cbl_o,
    output logic [7:0] cblen_o,
    output logic [7:0] csl_o,
    output logic [7:0] din_o,
    output logic [7:0] dinb_o,
    input  logic [7:0] dout_i
);
    localparam int CW = PULSE_CYC > 1 ? $clog2(PULSE_CYC) : 1;

    typedef enum logic [3:0] {
        IDLE, W_SETA, W_PA, W_SETB, W_PB, W_END, R_SET, R_ARM, R_EVAL, R_END
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    row, f_row;
    logic [7:0]    wdata, wmask, din, dinb, f_wdata, f_wmask, f_din, f_dinb;
    logic [7:0]    wl_q, wl_n, cbl_n, cblen_n, csl_n, din_n, dinb_n;
    logic          acc, wr, rd, seta;

    assign req_ready_o = state == IDLE;
    assign acc         = req_valid_i && req_ready_o;
    assign cwle_o      = wl_q[7:4];
    assign cwlo_o      = wl_q[3:0];

    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        case (state)
            IDLE:   if (req_valid_i) nxt = req_we_i ? W_SETA : R_SET;
            W_SETA: begin nxt = W_PA; cnt_n = CW'(PULSE_CYC - 1); end
            W_PA:   if (cnt == '0) nxt = W_SETB; else cnt_n = cnt - 1'b1;
            W_SETB: begin nxt = W_PB; cnt_n = CW'(PULSE_CYC - 1); end
            W_PB:   if (cnt == '0) nxt = W_END; else cnt_n = cnt - 1'b1;
            R_SET:  nxt = R_ARM;
            R_ARM:  nxt = R_EVAL;
            R_EVAL: nxt = R_END;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered lines line up with the state cycle.
    always_comb begin
        f_row   = acc ? req_row_i   : row;
        f_wdata = acc ? req_wdata_i : wdata;
        f_wmask = acc ? req_wmask_i : wmask;
        f_din   = acc ? req_din_i   : din;
        f_dinb  = acc ? req_dinb_i  : dinb;
        wr      = nxt inside {W_SETA, W_PA, W_SETB, W_PB};
        rd      = nxt inside {R_SET, R_ARM, R_EVAL};
        seta    = nxt inside {W_SETA, W_PA};
        wl_n    = (nxt inside {W_PA, W_PB, R_ARM, R_EVAL}) ? 8'd1 << {f_row[0], f_row[2:1]} : 8'd0;
        cblen_n = wr ? f_wmask : 8'd0;
        cbl_n   = wr ? ~f_wdata & f_wmask : 8'd0;
        csl_n   = wr ? (seta ? f_wdata : ~f_wdata) & f_wmask : (nxt == R_ARM ? 8'hFF : 8'd0);
        din_n   = rd ? f_din : 8'd0;
        dinb_n  = rd ? f_dinb : 8'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            row         <= '0;
            wdata       <= '0;
            wmask       <= '0;
            din         <= '0;
            dinb        <= '0;
            wl_q        <= '0;
            cbl_o       <= '0;
            cblen_o     <= '0;
            csl_o       <= '0;
            din_o       <= '0;
            dinb_o      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            state       <= nxt;
            cnt         <= cnt_n;
            row         <= f_row;
            wdata       <= f_wdata;
            wmask       <= f_wmask;
            din         <= f_din;
            dinb        <= f_dinb;
            wl_q        <= wl_n;
            cbl_o       <= cbl_n;
            cblen_o     <= cblen_n;
            csl_o       <= csl_n;
            din_o       <= din_n;
            dinb_o      <= dinb_n;
            rsp_valid_o <= nxt inside {W_END, R_END};
            if (state == R_EVAL) rsp_rdata_o <= ~dout_i;
        end
    end
endmodule

// File: tb/tb_mc_8x8_ctrl.sv
// tb_mc_8x8_ctrl: directed bench with a behavioural complementary-cell array model driving dout.
module tb_mc_8x8_ctrl;
    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rq_valid = 1'b0, rq_we = 1'b0;
    logic [2:0] rq_row = '0;
    logic [7:0] rq_wdata = '0, rq_wmask = '0, rq_din = '0, rq_dinb = '0;
    logic       ready, rsp_valid;
    logic [7:0] rdata, o_cbl, o_cblen, o_csl, o_din, o_dinb, dout;
    logic [3:0] o_cwle, o_cwlo;
    logic [7:0] wlv;
    logic [7:0] m0 [8];
    logic [7:0] m1 [8];
    int ncmp = 0, nfail = 0;

    always #5 clk = ~clk;

    mc_8x8_ctrl #(.PULSE_CYC(P)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rq_valid), .req_ready_o(ready),
        .req_we_i(rq_we), .req_row_i(rq_row), .req_wdata_i(rq_wdata), .req_wmask_i(rq_wmask),
        .req_din_i(rq_din), .req_dinb_i(rq_dinb), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rdata),
        .cwle_o(o_cwle), .cwlo_o(o_cwlo), .cbl_o(o_cbl), .cblen_o(o_cblen), .csl_o(o_csl),
        .din_o(o_din), .dinb_o(o_dinb), .dout_i(dout)
    );

    assign wlv = {o_cwle, o_cwlo};

    // Array model: wl bit k<4 is even row 2k, k>=4 is odd row 2(k-4)+1.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (wlv[k]) begin
                for (int i = 0; i < 8; i++) begin
                    if (o_cblen[i]) begin
                        if (o_csl[i] != o_cbl[i]) m0[k < 4 ? 2*k : 2*(k-4)+1][i] <= o_csl[i];
                        else m1[k < 4 ? 2*k : 2*(k-4)+1][i] <= o_cbl[i];
                    end
                end
            end
        end
    end

    always_comb begin
        dout = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            if (wlv[k]) begin
                dout = ~(((m0[k < 4 ? 2*k : 2*(k-4)+1] & ~m1[k < 4 ? 2*k : 2*(k-4)+1]) & o_din)
                       | (~(m0[k < 4 ? 2*k : 2*(k-4)+1] & ~m1[k < 4 ? 2*k : 2*(k-4)+1]) & o_dinb));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wl_bit(input logic [2:0] r);
        return r[0] ? 8'h10 << r[2:1] : 8'h01 << r[2:1];
    endfunction

    task automatic issue(input logic we, input logic [2:0] r, input logic [7:0] d, m, dn, dnb);
        @(negedge clk);
        chk("ready_before_req", {31'd0, ready}, 32'd1);
        rq_valid = 1'b1; rq_we = we; rq_row = r; rq_wdata = d; rq_wmask = m; rq_din = dn; rq_dinb = dnb;
        @(posedge clk);
        #1;
        rq_valid = 1'b0; rq_we = $urandom; rq_row = 3'($urandom); rq_wdata = 8'($urandom);
        rq_wmask = 8'($urandom); rq_din = 8'($urandom); rq_dinb = 8'($urandom);
    endtask

    task automatic do_write(input logic [2:0] r, input logic [7:0] d, m);
        logic act, pulse, pa;
        issue(1'b1, r, d, m, 8'($urandom), 8'($urandom));
        for (int c = 1; c <= 3 + 2*P; c++) begin
            @(negedge clk);
            act   = c <= 2 + 2*P;
            pulse = (c >= 2 && c <= 1 + P) || (c >= 3 + P && c <= 2 + 2*P);
            pa    = c <= 1 + P;
            chk($sformatf("w_wl_c%0d", c), {24'd0, wlv}, {24'd0, pulse ? wl_bit(r) : 8'd0});
            chk($sformatf("w_cblen_c%0d", c), {24'd0, o_cblen}, {24'd0, act ? m : 8'd0});
            chk($sformatf("w_cbl_c%0d", c), {24'd0, o_cbl}, {24'd0, act ? ~d & m : 8'd0});
            chk($sformatf("w_csl_c%0d", c), {24'd0, o_csl}, {24'd0, act ? (pa ? d : ~d) & m : 8'd0});
            chk($sformatf("w_din_c%0d", c), {16'd0, o_din, o_dinb}, 32'd0);
            chk($sformatf("w_rsp_c%0d", c), {31'd0, rsp_valid}, {31'd0, c == 3 + 2*P});
            chk($sformatf("w_ready_c%0d", c), {31'd0, ready}, 32'd0);
        end
    endtask

    task automatic do_read(input logic [2:0] r, input logic [7:0] dn, dnb, exp);
        issue(1'b0, r, 8'($urandom), 8'($urandom), dn, dnb);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("r_wl_c%0d", c), {24'd0, wlv}, {24'd0, (c == 2 || c == 3) ? wl_bit(r) : 8'd0});
            chk($sformatf("r_csl_c%0d", c), {24'd0, o_csl}, {24'd0, c == 2 ? 8'hFF : 8'd0});
            chk($sformatf("r_cbl_c%0d", c), {16'd0, o_cbl, o_cblen}, 32'd0);
            chk($sformatf("r_din_c%0d", c), {16'd0, o_din, o_dinb}, {16'd0, c <= 3 ? {dn, dnb} : 16'd0});
            chk($sformatf("r_rsp_c%0d", c), {31'd0, rsp_valid}, {31'd0, c == 4});
        end
        chk($sformatf("r_rdata_row%0d", r), {24'd0, rdata}, {24'd0, exp});
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin m0[r] = '0; m1[r] = '0; end
        #12;
        chk("rst_lines", {wlv, o_cbl, o_cblen, o_csl}, 32'd0);
        chk("rst_din", {16'd0, o_din, o_dinb}, 32'd0);
        chk("rst_rsp", {23'd0, rsp_valid, rdata}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(3'd5, 8'hA5, 8'hFF);
        do_read(3'd5, 8'hFF, 8'h00, 8'hA5);
        do_read(3'd5, 8'hF0, 8'h0F, 8'hAA);
        do_write(3'd5, 8'h00, 8'h0F);
        do_read(3'd5, 8'hFF, 8'h00, 8'hA0);
        do_write(3'd0, 8'h3C, 8'hFF);
        do_write(3'd1, 8'hC3, 8'hFF);
        do_read(3'd0, 8'hFF, 8'h00, 8'h3C);
        do_read(3'd1, 8'hFF, 8'h00, 8'hC3);
        do_read(3'd5, 8'hFF, 8'h00, 8'hA0);
        do_write(3'd2, 8'h5A, 8'h00);
        do_read(3'd2, 8'hFF, 8'h00, 8'h00);
        issue(1'b1, 3'd6, 8'h81, 8'hFF, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_wl_before", {24'd0, wlv}, {24'd0, wl_bit(3'd6)});
        rst_n = 1'b0;
        #1;
        chk("abort_lines", {wlv, o_cbl, o_cblen, o_csl}, 32'd0);
        chk("abort_din", {16'd0, o_din, o_dinb}, 32'd0);
        chk("abort_rsp", {23'd0, rsp_valid, rdata}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("abort_norsp_%0d", c), {31'd0, rsp_valid}, 32'd0);
        end
        do_read(3'd0, 8'hFF, 8'h00, 8'h3C);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
